// File: rtl/num2str.sv
// num2str: converts a 16-bit number to an ASCII decimal string, one character per handshake, 8'h00-terminated.
// Define NUM2STR_SIGNED_EN to treat Num as two's complement and emit a leading '-'.
module num2str (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [15:0] Num,
    input  logic        CharAck,
    output logic        Ready,
    output logic [7:0]  Char,
    output logic        CharValid,
    output logic        Done
);
    typedef enum logic [2:0] {IDLE, INIT, SIGN, DIGIT, EMIT, TERM} state_t;

    state_t      state_q, state_d;
    logic [15:0] rem_q, rem_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  k_q, k_d;
    logic        neg_q, neg_d;
    logic        lead_q, lead_d;
    logic        done_q, done_d;
    logic        neg_in;
    logic [15:0] mag;
    logic [15:0] pow;

`ifdef NUM2STR_SIGNED_EN
    assign neg_in = Num[15];
`else
    assign neg_in = 1'b0;
`endif
    // 16'h8000 negates to itself, which read unsigned is exactly 32768
    assign mag = neg_in ? ~Num + 16'd1 : Num;

    always_comb begin
        pow = k_q == 3'd4 ? 16'd10000 :
              k_q == 3'd3 ? 16'd1000  :
              k_q == 3'd2 ? 16'd100   :
              k_q == 3'd1 ? 16'd10    : 16'd1;
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        neg_d   = neg_q;
        lead_d  = lead_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (Start) begin
                state_d = INIT;
                rem_d   = mag;
                neg_d   = neg_in;
                k_d     = 3'd4;
                cnt_d   = 4'd0;
                lead_d  = 1'b1;
            end
            INIT: state_d = neg_q ? SIGN : DIGIT;
            SIGN: if (CharAck) state_d = DIGIT;
            DIGIT: begin
                if (rem_q >= pow) begin
                    rem_d = rem_q - pow;
                    cnt_d = cnt_q + 4'd1;
                end else if (cnt_q != 4'd0 || !lead_q || k_q == 3'd0) begin
                    state_d = EMIT;
                    lead_d  = 1'b0;
                end else begin
                    k_d = k_q - 3'd1;
                end
            end
            EMIT: if (CharAck) begin
                if (k_q == 3'd0) begin
                    state_d = TERM;
                end else begin
                    state_d = DIGIT;
                    k_d     = k_q - 3'd1;
                    cnt_d   = 4'd0;
                end
            end
            TERM: if (CharAck) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            rem_q   <= 16'd0;
            cnt_q   <= 4'd0;
            k_q     <= 3'd4;
            neg_q   <= 1'b0;
            lead_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            neg_q   <= neg_d;
            lead_q  <= lead_d;
            done_q  <= done_d;
        end
    end

    assign Ready     = state_q == IDLE;
    assign CharValid = state_q == SIGN || state_q == EMIT || state_q == TERM;
    assign Char      = state_q == SIGN ? 8'h2D : state_q == EMIT ? {4'h3, cnt_q} : 8'h00;
    assign Done      = done_q;
endmodule

// File: tb/tb_num2str.sv
// tb_num2str: scoreboard bench for num2str; stimulus queues expected characters, a negedge monitor checks them.
module tb_num2str;
    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Start = 1'b0;
    logic [15:0] Num = 16'd0;
    logic        CharAck = 1'b0;
    logic        Ready;
    logic [7:0]  Char;
    logic        CharValid;
    logic        Done;

    int checks = 0;
    int errors = 0;
    logic [7:0] q[$];
    logic       prev_term = 1'b0;
    logic       prev_hold = 1'b0;
    logic [7:0] held = 8'h00;

    num2str dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Num(Num), .CharAck(CharAck),
        .Ready(Ready), .Char(Char), .CharValid(CharValid), .Done(Done)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Monitor: inputs are stable here, so valid&ack means the next rising edge accepts Char
    always @(negedge Clk) begin
        if (Rst) begin
            prev_term = 1'b0;
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", {15'd0, CharValid}, 16'd1);
                check("hold_char", {8'd0, Char}, {8'd0, held});
            end
            if (Done || prev_term) check("done", {15'd0, Done}, {15'd0, prev_term});
            prev_term = 1'b0;
            if (CharValid && CharAck) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_char: got %h, expected none", Char);
                end else begin
                    check("char", {8'd0, Char}, {8'd0, q.pop_front()});
                    prev_term = Char == 8'h00;
                end
            end
            prev_hold = CharValid && !CharAck;
            held = Char;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic start_conv(input logic [15:0] n, input string s);
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        q.push_back(8'h00);
        Start = 1'b1;
        Num = n;
        tick();
        Start = 1'b0;
        Num = 16'hA5A5;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (!(q.size() == 0 && Ready) && cyc < 200) begin
            tick();
            cyc++;
        end
        if (cyc >= 200) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d pending chars, expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic run(input logic [15:0] n, input string s);
        int c;
        CharAck = 1'b1;
        start_conv(n, s);
        wait_idle(c);
        tick();
    endtask

    initial begin
        int c;
        #1;
        check("rst_ready", {15'd0, Ready}, 16'd1);
        check("rst_valid", {15'd0, CharValid}, 16'd0);
        check("rst_char", {8'd0, Char}, 16'd0);
        check("rst_done", {15'd0, Done}, 16'd0);
        tick();
        Rst = 1'b0;
        tick();

        run(16'd1234, "1234");
        run(16'd0, "0");
        run(16'd50, "50");
`ifdef NUM2STR_SIGNED_EN
        run(16'h8000, "-32768");
        run(16'hFFFF, "-1");
        run(16'hFB2E, "-1234");
        run(16'd32767, "32767");
`else
        CharAck = 1'b1;
        start_conv(16'hFFFF, "65535");
        wait_idle(c);
        check("latency", {15'd0, c <= 60}, 16'd1);
        tick();
        run(16'h8000, "32768");
`endif

        // backpressure in EMIT with Start pulses that must be ignored
        CharAck = 1'b1;
        start_conv(16'd1005, "1005");
        for (int i = 0; i < 100 && !(q.size() <= 4 && CharValid); i++) tick();
        CharAck = 1'b0;
        for (int i = 0; i < 5; i++) begin
            Start = i[0];
            Num = 16'd9;
            tick();
        end
        Start = 1'b0;
        check("busy_ready", {15'd0, Ready}, 16'd0);
        CharAck = 1'b1;
        wait_idle(c);
        tick();

        // reset mid-string, then a fresh conversion
        CharAck = 1'b1;
        start_conv(16'd12345, "12345");
        for (int i = 0; i < 100 && !(q.size() <= 4 && CharValid); i++) tick();
        #2;
        Rst = 1'b1;
        #1;
        check("midrst_valid", {15'd0, CharValid}, 16'd0);
        check("midrst_ready", {15'd0, Ready}, 16'd1);
        check("midrst_char", {8'd0, Char}, 16'd0);
        q.delete();
        tick();
        Rst = 1'b0;
        run(16'd7, "7");
        tick();
        check("end_ready", {15'd0, Ready}, 16'd1);
        check("end_pending", q.size(), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
